// File: rtl/stack_arb.sv
// Two-requester round-robin front end for an external hardware stack.
// Ops flow through an execute stage (E) and a response register (R); depth is tracked at acceptance.
module stack_arb #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_valid,
  input  logic [1:0]    r0_op,
  input  logic [DW-1:0] r0_data,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [1:0]    r1_op,
  input  logic [DW-1:0] r1_data,
  output logic          r1_ready,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_data,
  output logic [2:0]    stk_cmd,
  output logic [DW-1:0] stk_in,
  input  logic [DW-1:0] stk_s0,
  output logic [AW+1:0] depth,
  output logic          empty,
  output logic          full
);

  // Handshake: a requester transfers on rN_valid & rN_ready; the response
  // side transfers on rsp_valid & rsp_ready and holds rsp_* stable otherwise.

  localparam logic [1:0]    OP_PEEK    = 2'b00;
  localparam logic [1:0]    OP_PUSH    = 2'b01;
  localparam logic [1:0]    OP_POP     = 2'b10;
  localparam logic [1:0]    OP_REPLACE = 2'b11;
  localparam logic [AW+1:0] DEPTH_V    = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] ONE_V      = (AW+2)'(1);

  logic          prio_q, prio_d;
  logic [AW+1:0] depth_q, depth_d;
  logic [2:0]    stk_cmd_q, stk_cmd_d;
  logic [DW-1:0] stk_in_q, stk_in_d;
  logic          e_valid_q, e_valid_d;
  logic          e_first_q, e_first_d;
  logic          e_id_q, e_id_d;
  logic          e_err_q, e_err_d;
  logic [DW-1:0] e_top_q, e_top_d;
  logic          r_valid_q, r_valid_d;
  logic          r_id_q, r_id_d;
  logic          r_err_q, r_err_d;
  logic [DW-1:0] r_data_q, r_data_d;

  logic          gnt0, gnt1, accept_ok, acc, e_adv, illegal;
  logic [1:0]    sel_op;
  logic [DW-1:0] sel_data, e_pre_top;
  logic [2:0]    sel_cmd;

  always_comb begin
    // prio_q=1 means r1 wins a tie.
    gnt1      = r1_valid && (!r0_valid || prio_q);
    gnt0      = r0_valid && !gnt1;
    accept_ok = !e_valid_q || !r_valid_q || rsp_ready;
    r0_ready  = gnt0 && accept_ok;
    r1_ready  = gnt1 && accept_ok;
    acc       = r0_ready || r1_ready;
    sel_op    = gnt1 ? r1_op : r0_op;
    sel_data  = gnt1 ? r1_data : r0_data;
    e_adv     = e_valid_q && (!r_valid_q || rsp_ready);
    // Top of stack is only valid to sample in E's command cycle; later it is held.
    e_pre_top = e_first_q ? stk_s0 : e_top_q;

    illegal = 1'b0;
    sel_cmd = 3'b000;
    case (sel_op)
      OP_PUSH:    begin illegal = (depth_q == DEPTH_V); sel_cmd = 3'b110; end
      OP_POP:     begin illegal = (depth_q == '0);      sel_cmd = 3'b001; end
      OP_REPLACE: begin illegal = (depth_q == '0);      sel_cmd = 3'b100; end
      OP_PEEK:    begin illegal = (depth_q == '0);      sel_cmd = 3'b000; end
      default:    begin illegal = 1'b0;                 sel_cmd = 3'b000; end
    endcase
  end

  always_comb begin
    prio_d    = prio_q;
    depth_d   = depth_q;
    stk_cmd_d = 3'b000;
    stk_in_d  = stk_in_q;
    e_valid_d = e_valid_q;
    e_first_d = 1'b0;
    e_id_d    = e_id_q;
    e_err_d   = e_err_q;
    e_top_d   = e_pre_top;
    r_valid_d = r_valid_q;
    r_id_d    = r_id_q;
    r_err_d   = r_err_q;
    r_data_d  = r_data_q;

    if (acc) begin
      prio_d    = !gnt1;
      stk_cmd_d = illegal ? 3'b000 : sel_cmd;
      if (!illegal && sel_cmd[2]) stk_in_d = sel_data;
      if (!illegal && sel_op == OP_PUSH) depth_d = depth_q + ONE_V;
      if (!illegal && sel_op == OP_POP)  depth_d = depth_q - ONE_V;
    end

    // accept implies E is empty or draining this cycle, so E can always take it.
    if (acc) begin
      e_valid_d = 1'b1;
      e_first_d = 1'b1;
      e_id_d    = gnt1;
      e_err_d   = illegal;
    end else if (e_adv) begin
      e_valid_d = 1'b0;
    end

    if (e_adv) begin
      r_valid_d = 1'b1;
      r_id_d    = e_id_q;
      r_err_d   = e_err_q;
      r_data_d  = e_err_q ? '0 : e_pre_top;
    end else if (rsp_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q    <= 1'b0;
      depth_q   <= '0;
      stk_cmd_q <= 3'b000;
      stk_in_q  <= '0;
      e_valid_q <= 1'b0;
      e_first_q <= 1'b0;
      e_id_q    <= 1'b0;
      e_err_q   <= 1'b0;
      e_top_q   <= '0;
      r_valid_q <= 1'b0;
      r_id_q    <= 1'b0;
      r_err_q   <= 1'b0;
      r_data_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      depth_q   <= depth_d;
      stk_cmd_q <= stk_cmd_d;
      stk_in_q  <= stk_in_d;
      e_valid_q <= e_valid_d;
      e_first_q <= e_first_d;
      e_id_q    <= e_id_d;
      e_err_q   <= e_err_d;
      e_top_q   <= e_top_d;
      r_valid_q <= r_valid_d;
      r_id_q    <= r_id_d;
      r_err_q   <= r_err_d;
      r_data_q  <= r_data_d;
    end
  end

  assign rsp_valid = r_valid_q;
  assign rsp_id    = r_id_q;
  assign rsp_err   = r_err_q;
  assign rsp_data  = r_data_q;
  assign stk_cmd   = stk_cmd_q;
  assign stk_in    = stk_in_q;
  assign depth     = depth_q;
  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DEPTH_V);

endmodule
